// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with double-buffered, frame-synchronous display update.
// Optional leading-zero blanking is compiled in with macro SEG_SCAN_LZB_EN.
module seg_scan_driver #(
  parameter int NDIG           = 4,
  parameter int PRESCALE       = 12000,
  parameter int DEAD           = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [4*NDIG-1:0] DATA,
  input  logic [NDIG-1:0]   DP,
  input  logic              LOAD,
  output logic [7:0]        SEG,
  output logic [NDIG-1:0]   AN,
  output logic              UPDATED
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]   IDX_MAX = IW'(NDIG - 1);
  localparam logic [7:0]      SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NDIG-1:0] AN_OFF  = DIG_ACTIVE_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [CW-1:0]     cnt_p0;
  logic [IW-1:0]     idx_p0;
  logic [4*NDIG-1:0] pend_data;
  logic [NDIG-1:0]   pend_dp;
  logic              pend_flag;
  logic [4*NDIG-1:0] disp_data;
  logic [NDIG-1:0]   disp_dp;
  logic              frame_end;

  assign frame_end = (cnt_p0 == CNT_MAX) && (idx_p0 == IDX_MAX);

  // Stage p0: slot counter and digit index
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (cnt_p0 == CNT_MAX) begin
      cnt_p0 <= '0;
      idx_p0 <= (idx_p0 == IDX_MAX) ? '0 : idx_p0 + 1'b1;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // A LOAD on the frame boundary bypasses the pending buffer entirely
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
      UPDATED   <= 1'b0;
    end else begin
      UPDATED <= 1'b0;
      if (frame_end && LOAD) begin
        disp_data <= DATA;
        disp_dp   <= DP;
        pend_flag <= 1'b0;
        UPDATED   <= 1'b1;
      end else if (frame_end && pend_flag) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        pend_flag <= 1'b0;
        UPDATED   <= 1'b1;
      end else if (LOAD) begin
        pend_data <= DATA;
        pend_dp   <= DP;
        pend_flag <= 1'b1;
      end
    end
  end

  logic [3:0]      nib;
  logic            in_dead;
  logic [6:0]      seg_glyph;
  logic [7:0]      seg_n;
  logic [NDIG-1:0] an_n;

`ifdef SEG_SCAN_LZB_EN
  logic blank;
  always_comb begin
    blank = 1'b0;
    if (idx_p0 != '0)
      blank = ((disp_data >> {idx_p0, 2'b00}) == '0);
  end
`endif

  always_comb begin
    nib       = disp_data[{idx_p0, 2'b00} +: 4];
    in_dead   = (int'(cnt_p0) < DEAD);
    seg_glyph = glyph(nib);
`ifdef SEG_SCAN_LZB_EN
    if (blank)
      seg_glyph = 7'h00;
`endif
    seg_n = 8'h00;
    an_n  = '0;
    if (!in_dead) begin
      seg_n = {disp_dp[idx_p0], seg_glyph};
      an_n  = NDIG'(1) << idx_p0;
    end
  end

  // Stage p1: registered outputs, polarity applied here only
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      SEG <= SEG_OFF;
      AN  <= AN_OFF;
    end else begin
      SEG <= seg_n ^ SEG_OFF;
      AN  <= an_n ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-arithmetic reference model queues expected outputs, a monitor checks them.
module tb_seg_scan_driver;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;
  localparam int DEAD     = 1;
  localparam int FRAME    = NDIG * PRESCALE;

  logic        CLK  = 1'b0;
  logic        RSTN = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] DATA = 16'h0;
  logic [3:0]  DP   = 4'h0;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic        UPDATED;

  seg_scan_driver #(
    .NDIG(NDIG), .PRESCALE(PRESCALE), .DEAD(DEAD),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .DATA(DATA), .DP(DP), .LOAD(LOAD),
    .SEG(SEG), .AN(AN), .UPDATED(UPDATED)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       upd;
  } exp_t;

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference state: cycles since reset release, shown and queued values
  int          model_n = 0;
  logic [15:0] m_disp  = 16'h0;
  logic [3:0]  m_ddp   = 4'h0;
  logic [15:0] m_pend  = 16'h0;
  logic [3:0]  m_pdp   = 4'h0;
  bit          m_pflag = 1'b0;

  function automatic exp_t inactive();
    exp_t e;
    e.seg = 8'h00;
    e.an  = 4'hF;
    e.upd = 1'b0;
    return e;
  endfunction

  function automatic exp_t view(int n, logic [15:0] d, logic [3:0] dp);
    exp_t e;
    int slot_pos, dg;
    logic [15:0] upper;
    logic [3:0]  nib;
    e = inactive();
    slot_pos = n % PRESCALE;
    dg       = (n / PRESCALE) % NDIG;
    if (slot_pos >= DEAD) begin
      upper = d >> (4 * dg);
      nib   = upper[3:0];
      e.seg = {dp[dg], glyph_tab[nib][6:0]};
`ifdef SEG_SCAN_LZB_EN
      if (dg > 0 && upper == 16'h0) e.seg[6:0] = 7'h00;
`endif
      e.an = ~(4'b0001 << dg);
    end
    return e;
  endfunction

  always @(negedge RSTN) begin
    exp_q.delete();
    exp_q.push_back(inactive());
    model_n = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pflag = 1'b0;
  end

  always @(posedge CLK) begin
    exp_t e;
    bit   frame_last;
    if (!RSTN) begin
      model_n = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pflag = 1'b0;
      exp_q.push_back(inactive());
    end else begin
      e = view(model_n, m_disp, m_ddp);
      frame_last = ((model_n % FRAME) == FRAME - 1);
      if (frame_last && LOAD) begin
        m_disp = DATA; m_ddp = DP; m_pflag = 1'b0; e.upd = 1'b1;
      end else if (frame_last && m_pflag) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pflag = 1'b0; e.upd = 1'b1;
      end else if (LOAD) begin
        m_pend = DATA; m_pdp = DP; m_pflag = 1'b1;
      end
      exp_q.push_back(e);
      model_n++;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL queue_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      check("seg", 32'(SEG), 32'(e.seg));
      check("an", 32'(AN), 32'(e.an));
      check("updated", 32'(UPDATED), 32'(e.upd));
    end
  end

  task automatic tick(int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_load(logic [15:0] d, logic [3:0] p);
    LOAD = 1'b1; DATA = d; DP = p;
    tick(1);
    LOAD = 1'b0; DATA = 16'($urandom); DP = 4'($urandom);
  endtask

  task automatic wait_pos(int pos);
    int guard = 0;
    while ((model_n % FRAME) != pos && guard < 2 * FRAME) begin
      tick(1);
      guard++;
    end
    if ((model_n % FRAME) != pos) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pos timeout: got %0d expected %0d", model_n % FRAME, pos);
    end
  endtask

  task automatic do_reset(int k);
    LOAD = 1'b0;
    RSTN = 1'b0;
    #1;
    check("reset_seg_now", 32'(SEG), 32'h00);
    check("reset_an_now", 32'(AN), 32'hF);
    check("reset_upd_now", 32'(UPDATED), 32'h0);
    tick(k);
    RSTN = 1'b1;
  endtask

  initial begin
    int r;
    tick(3);
    RSTN = 1'b1;
    tick(6);
    pulse_load(16'h12AF, 4'h0);
    tick(2 * FRAME);

    wait_pos(2);
    pulse_load(16'h1111, 4'h0);
    tick(3);
    pulse_load(16'h2222, 4'h0);
    tick(2 * FRAME);

    wait_pos(FRAME - 1);
    pulse_load(16'hABCD, 4'b0101);
    tick(FRAME + 2);

    wait_pos(4);
    pulse_load(16'h0050, 4'b0100);
    tick(2 * FRAME);

    do_reset(2);
    tick(FRAME);
    wait_pos(5);
    pulse_load(16'h9876, 4'hF);
    wait_pos(9);
    do_reset(2);
    tick(2 * FRAME);

    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        pulse_load(16'($urandom), 4'($urandom));
      end else if (r < 8) begin
        wait_pos(FRAME - 1);
        pulse_load(16'($urandom), 4'($urandom));
      end else if (r == 8) begin
        pulse_load(16'h0000 | 16'($urandom_range(0, 255)), 4'($urandom));
      end else begin
        do_reset($urandom_range(1, 3));
      end
      tick($urandom_range(0, 20));
    end
    tick(2 * FRAME);
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter PRESCALE, default 12000, giving the clock cycles per digit slot (legal >= 2).
REQ-003 The block SHALL have parameter DEAD, default 16, giving the blanked cycles at the start of each slot (legal 0..PRESCALE-1).
REQ-004 The block SHALL have parameter SEG_ACTIVE_LOW, default 0, which inverts SEG when 1.
REQ-005 The block SHALL have parameter DIG_ACTIVE_LOW, default 1, which makes AN active-low when 1.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port RSTN, input, 1 bit: the asynchronous active-low reset.
REQ-009 The block SHALL have port DATA, input, 4*NDIG bits: hex nibbles, with nibble i driving digit i (digit 0 is least significant).
REQ-010 The block SHALL have port DP, input, NDIG bits: the decimal point for each digit.
REQ-011 The block SHALL have port LOAD, input, 1 bit: a one-cycle request to capture DATA and DP.
REQ-012 The block SHALL have port SEG, output, 8 bits: SEG[6:0] drives segments g..a and SEG[7] drives dp.
REQ-013 The block SHALL have port AN, output, NDIG bits: the digit enables.
REQ-014 The block SHALL have port UPDATED, output, 1 bit: a one-cycle pulse when pending data becomes the displayed data.

Function
REQ-015 The block SHALL use a glyph table (true polarity, bit7..0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
REQ-016 The slot counter SHALL count 0..PRESCALE-1 and wrap to 0.
REQ-017 At the wrap, the digit index SHALL advance 0..NDIG-1 and wrap to 0.
REQ-018 The frame boundary SHALL be the cycle in which the counter equals PRESCALE-1 and the index equals NDIG-1.
REQ-019 LOAD=1 SHALL capture DATA and DP into the pending registers and set the pending flag.
REQ-020 Multiple LOADs within one frame SHALL be resolved so that the last one wins.
REQ-021 At the frame boundary with the pending flag set, the pending registers SHALL copy to the display registers, the flag SHALL clear, and UPDATED SHALL pulse on the next cycle.
REQ-022 When LOAD coincides with the frame boundary, the DATA and DP of that same cycle SHALL go directly to the display registers, UPDATED SHALL pulse, and the flag SHALL end up cleared.
REQ-023 During the slot of digit i, with counter >= DEAD, AN SHALL assert only bit i and SEG SHALL carry glyph(nibble i) with SEG[7]=DP[i].
REQ-024 With counter < DEAD, all AN bits SHALL be inactive and all SEG bits SHALL be inactive (anti-ghosting).
REQ-025 SEG and AN SHALL be registered, lagging the counter and index by exactly one cycle.
REQ-026 Polarity SHALL be applied at the output register only.
REQ-027 With NDIG=1, the index SHALL stay 0 and the frame boundary SHALL occur at every slot wrap.

Reset
REQ-028 While RSTN=0, the counter, index, pending and display registers, pending flag and UPDATED SHALL all be 0.
REQ-029 While RSTN=0, SEG and AN SHALL be at their inactive levels.
REQ-030 Reset asserted mid-frame SHALL discard any pending LOAD.
REQ-031 After release, scanning SHALL restart at digit 0 with the counter at 0.

Configuration
REQ-032 The block SHALL provide macro SEG_SCAN_LZB_EN to compile in leading-zero blanking.
REQ-033 With SEG_SCAN_LZB_EN defined, digit i>0 SHALL have SEG[6:0] inactive when its nibble and all higher nibbles of the display register are 0.
REQ-034 With SEG_SCAN_LZB_EN defined, digit 0 SHALL never be blanked, and DP SHALL still be shown on blanked digits.
REQ-035 With SEG_SCAN_LZB_EN undefined, every digit SHALL show its glyph and no blanking logic SHALL exist.

Verification (NDIG=4, PRESCALE=4, DEAD=1, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1)
REQ-036 The bench SHALL cover: RSTN low -> SEG=00, AN=1111, UPDATED=0; release -> first enabled digit is AN=1110 at slot 0, counter 1, plus one cycle.
REQ-037 The bench SHALL cover: LOAD DATA=12AF, DP=0000 mid-frame -> display unchanged until the boundary, then UPDATED pulses and the next frame shows slot0 71/1110, slot1 77/1101, slot2 5B/1011, slot3 06/0111, each preceded by 1 cycle of 00/1111.
REQ-038 The bench SHALL cover: LOAD 1111 then LOAD 2222 in the same frame -> only 2222 is displayed, with a single UPDATED pulse.
REQ-039 The bench SHALL cover: LOAD DATA=ABCD asserted exactly on the boundary cycle -> UPDATED on the next cycle and ABCD shown from digit 0 of the new frame.
REQ-040 The bench SHALL cover, with LZB defined: DATA=0050, DP=0100 -> digit3 00, digit2 80, digit1 6D, digit0 3F; with LZB undefined, digit3 3F and digit2 BF.
REQ-041 The bench SHALL cover: RSTN pulsed low during slot 2 with LOAD pending -> outputs inactive at once, and after release the display still shows the old value (0000 -> 3F on all digits when LZB is undefined).
